// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with the HI/LO register pair.
// Stalls EX for WIDTH+1 cycles and also services MTHI/MTLO.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] opb_q;
    logic             qsign_q;
    logic             rsign_q;
    logic             is_div_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             op_mul;
    logic             op_div;
    logic             op_sgn;
    logic             op_mthi;
    logic             op_mtlo;
    logic             issue;
    logic             idle_wr;

    always_comb begin
        op_mul  = 1'b0;
        op_div  = 1'b0;
        op_sgn  = 1'b0;
        op_mthi = 1'b0;
        op_mtlo = 1'b0;
        case (alucontrol)
            EXE_MULT_OP: begin
                op_mul = 1'b1;
                op_sgn = 1'b1;
            end
            EXE_MULTU_OP: op_mul = 1'b1;
            EXE_DIV_OP: begin
                op_div = 1'b1;
                op_sgn = 1'b1;
            end
            EXE_DIVU_OP: op_div  = 1'b1;
            EXE_MTHI_OP: op_mthi = 1'b1;
            EXE_MTLO_OP: op_mtlo = 1'b1;
            default: ;
        endcase
    end

    assign idle_wr = (state_q == S_IDLE) && en && !flush;
    assign issue   = idle_wr && (op_mul || op_div);

    // Operand magnitudes; signed ops work on |a| and |b|.
    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;

    always_comb begin
        mag_a_d = (op_sgn && a[WIDTH-1]) ? -a : a;
        mag_b_d = (op_sgn && b[WIDTH-1]) ? -b : b;
    end

    // Shift-add: acc = {partial, multiplier}, LSB of multiplier consumed per step.
    logic [WIDTH:0]  madd_d;
    logic [W2-1:0]   mul_step_d;

    always_comb begin
        madd_d = {1'b0, acc_q[W2-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step_d = {madd_d, acc_q[WIDTH-1:1]};
    end

    // Restoring divide: acc = {rem, dividend/quotient}, MSB first.
    logic [WIDTH:0]  rsh_d;
    logic [WIDTH:0]  diff_d;
    logic [W2-1:0]   div_step_d;

    always_comb begin
        rsh_d  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        diff_d = rsh_d - {1'b0, opb_q};
        if (diff_d[WIDTH]) begin
            div_step_d = {rsh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_step_d = {diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    logic [W2-1:0]    prod_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        prod_d = qsign_q ? -acc_q : acc_q;
        quo_d  = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d  = rsign_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
        if (is_div_q) begin
            // A zero divisor leaves the dividend as remainder; quotient is all ones.
            hi_d = rem_d;
            lo_d = div0_q ? '1 : quo_d;
        end else begin
            hi_d = prod_d[W2-1:WIDTH];
            lo_d = prod_d[WIDTH-1:0];
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_IDLE:  stall = issue;
            S_BUSY:  stall = !flush;
            default: stall = 1'b0;
        endcase
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        if (op_div) begin
                            acc_q <= {{WIDTH{1'b0}}, mag_a_d};
                            opb_q <= mag_b_d;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, mag_b_d};
                            opb_q <= mag_a_d;
                        end
                        qsign_q  <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_q  <= op_sgn && op_div && a[WIDTH-1];
                        is_div_q <= op_div;
                        div0_q   <= (b == '0);
                        cnt_q    <= '0;
                        state_q  <= S_BUSY;
                    end else if (idle_wr && op_mthi) begin
                        hi_q <= a;
                    end else if (idle_wr && op_mtlo) begin
                        lo_q <= a;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= is_div_q ? div_step_d : mul_step_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO,
// a monitor pops and compares once the unit releases the stall.
module tb_hilo_muldiv;

    localparam logic [7:0] OP_NOP   = 8'b00000000;
    localparam logic [7:0] OP_MFHI  = 8'b00010000;
    localparam logic [7:0] OP_MTHI  = 8'b00010001;
    localparam logic [7:0] OP_MFLO  = 8'b00010010;
    localparam logic [7:0] OP_MTLO  = 8'b00010011;
    localparam logic [7:0] OP_MULT  = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_DIV   = 8'b00011010;
    localparam logic [7:0] OP_DIVU  = 8'b00011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  alucontrol = OP_NOP;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .flush(flush),
        .alucontrol(alucontrol),
        .a(a),
        .b(b),
        .stall(stall),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    task automatic model(input logic [7:0] op, input logic [31:0] av,
                         input logic [31:0] bv, output logic [31:0] eh,
                         output logic [31:0] el);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'b0, av};
        ub = {32'b0, bv};
        eh = '0;
        el = '0;
        case (op)
            OP_MULT: begin
                p  = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                up = ua * ub;
                eh = up[63:32];
                el = up[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (bv == 0) begin
                    eh = av;
                    el = 32'hFFFFFFFF;
                end else if (op == OP_DIV) begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end else begin
                    el = 32'(ua / ub);
                    eh = 32'(ua % ub);
                end
            end
            default: ;
        endcase
    endtask

    // One muldiv instruction held in EX until it leaves; optional flush/reset cycle.
    task automatic do_op(input logic [7:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int flush_at,
                         input int rst_at);
        logic [31:0] eh, el;
        int n;
        int stop_t;
        bit done;
        model(op, av, bv, eh, el);
        if (flush_at >= 0) begin
            eh = m_hi;
            el = m_lo;
        end else if (rst_at >= 0) begin
            eh = '0;
            el = '0;
        end
        exp_q.push_back({eh, el});
        m_hi = eh;
        m_lo = el;
        stop_t = (flush_at >= 0) ? flush_at : (rst_at >= 0) ? rst_at : 33;
        @(negedge clk);
        en = 1'b1;
        alucontrol = op;
        a = av;
        b = bv;
        n = 0;
        done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (t > 0) @(negedge clk);
            if (t == flush_at) flush = 1'b1;
            if (t == rst_at) rst = 1'b1;
            #1;
            if (stall) n++;
            else done = 1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL stall_timeout: stall still high after 40 cycles");
        end
        chk("stall_cycles", 64'(n), 64'(stop_t));
        @(negedge clk);
        en = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        alucontrol = OP_NOP;
        #1;
        chk("no_reissue", 64'(stall), 64'd0);
    endtask

    task automatic do_mt(input logic [7:0] op, input logic [31:0] v,
                         input logic fl);
        @(negedge clk);
        en = 1'b1;
        alucontrol = op;
        a = v;
        flush = fl;
        #1;
        chk("mt_stall", 64'(stall), 64'd0);
        if (!fl && op == OP_MTHI) m_hi = v;
        if (!fl && op == OP_MTLO) m_lo = v;
        @(negedge clk);
        en = 1'b0;
        flush = 1'b0;
        alucontrol = OP_NOP;
        #1;
        chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    // Monitor: the cycle after stall falls, HI/LO must hold the queued result.
    initial begin
        bit prev = 0;
        bit pend = 0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (pend) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_empty: result with no expectation hi=%h lo=%h", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hilo", {hi, lo}, e);
                end
                pend = 0;
            end
            if (prev && !stall) pend = 1;
            prev = stall;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops[4];
        logic [7:0] op;
        logic [31:0] ra, rb;
        ops[0] = OP_MULT;
        ops[1] = OP_MULTU;
        ops[2] = OP_DIV;
        ops[3] = OP_DIVU;

        // Reset has priority over a muldiv issue attempt.
        @(negedge clk);
        en = 1'b1;
        alucontrol = OP_MULT;
        a = 32'd3;
        b = 32'd4;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        en = 1'b0;
        alucontrol = OP_NOP;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall_after", 64'(stall), 64'd0);

        do_op(OP_MULT, 32'hFFFFFFFD, 32'd5, -1, -1);
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
        do_op(OP_DIVU, 32'd100, 32'd7, -1, -1);
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1);
        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, -1, -1);
        do_op(OP_DIV, 32'd42, 32'd0, -1, -1);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1);
        do_op(OP_DIV, 32'hFFFFFF00, 32'd0, -1, -1);
        do_op(OP_MULT, 32'h80000000, 32'h80000000, -1, -1);

        do_mt(OP_MTHI, 32'h12345678, 1'b0);
        do_op(OP_DIVU, 32'd9, 32'd3, 10, -1);
        do_op(OP_MULT, 32'd1234, 32'hFFFFFF85, -1, -1);
        do_op(OP_MULT, 32'd77, 32'd99, -1, 20);

        do_mt(OP_MTLO, 32'hCAFEBABE, 1'b0);
        @(negedge clk);
        en = 1'b1;
        alucontrol = OP_MFLO;
        #1;
        chk("mflo_stall", 64'(stall), 64'd0);
        chk("mflo_lo", 64'(lo), 64'hCAFEBABE);
        @(negedge clk);
        alucontrol = OP_MFHI;
        #1;
        chk("mfhi_stall", 64'(stall), 64'd0);
        en = 1'b0;
        alucontrol = OP_NOP;

        // Flush in IDLE blocks both MTHI and muldiv issue.
        do_mt(OP_MTHI, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        en = 1'b1;
        flush = 1'b1;
        alucontrol = OP_DIVU;
        a = 32'd50;
        b = 32'd5;
        #1;
        chk("flush_issue_stall", 64'(stall), 64'd0);
        @(negedge clk);
        en = 1'b0;
        flush = 1'b0;
        alucontrol = OP_NOP;
        #1;
        chk("flush_issue_idle", 64'(stall), 64'd0);

        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                default: ;
            endcase
            do_op(op, ra, rb, -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
